data_memory_responder: RTL
==========================

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 The block SHALL have parameter MEMORY_DEPTH, default 32, meaning the number of 32-bit words stored.
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h1001_0000, meaning the byte address of word 0.
REQ-003 The block SHALL have parameter WAIT_STATES, default 2, meaning extra cycles between acceptance and response (legal range 0..15).
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port clk, input, 1 bit: the clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-007 The block SHALL have port req_valid_i, input, 1 bit: the processor presents a request.
REQ-008 The block SHALL have port req_ready_o, output, 1 bit: the responder can accept a request.
REQ-009 The block SHALL have port req_write_i, input, 1 bit: 1 for a store, 0 for a load.
REQ-010 The block SHALL have port req_addr_i, input, 32 bits: byte address.
REQ-011 The block SHALL have port req_wdata_i, input, 32 bits: store data.
REQ-012 The block SHALL have port req_be_i, input, 4 bits: byte enables; bit n selects wdata[8n+7:8n].
REQ-013 The block SHALL have port rsp_valid_o, output, 1 bit: a response is presented.
REQ-014 The block SHALL have port rsp_ready_i, input, 1 bit: the processor accepts the response.
REQ-015 The block SHALL have port rsp_rdata_o, output, 32 bits: load data; 0 for stores and errors.
REQ-016 The block SHALL have port rsp_error_o, output, 1 bit: the request was misaligned or out of range.

Function
REQ-017 The FSM SHALL have the states IDLE, WAIT and RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-018 Acceptance SHALL occur when req_valid_i and req_ready_o are both 1 on a clock edge; the block SHALL latch write, addr, wdata and be on that edge.
REQ-019 On acceptance, the FSM SHALL go to WAIT with the wait counter loaded to WAIT_STATES, or directly to RESP if WAIT_STATES=0.
REQ-020 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL go to RESP on the edge where the counter is 1; rsp_valid_o therefore rises exactly WAIT_STATES+1 cycles after acceptance.
REQ-021 In RESP, rsp_valid_o, rsp_rdata_o and rsp_error_o SHALL be held stable until rsp_valid_o and rsp_ready_i are both 1; the FSM SHALL then return to IDLE on that edge.
REQ-022 The minimum request-to-request spacing SHALL be WAIT_STATES+3 cycles, and the block SHALL hold only one request in flight.
REQ-023 The word index SHALL be (addr-BASE_ADDR)>>2, computed in 32-bit unsigned arithmetic with wrap-around.
REQ-024 The block SHALL set the error flag if addr[1:0]!=0, or if addr<BASE_ADDR, or if the index>=MEMORY_DEPTH.
REQ-025 An errored store SHALL NOT modify memory.
REQ-026 An errored load SHALL return rdata 0.
REQ-027 A valid store SHALL update only the bytes enabled by be, on the edge entering RESP; be=4'b0000 SHALL be a legal no-op store with no error.
REQ-028 A valid load SHALL read the word on the edge entering RESP, so that it observes all earlier completed stores.
REQ-029 Any change to req_* inputs while not in IDLE SHALL be ignored.

Reset
REQ-030 Reset SHALL force state IDLE, counter 0, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0 and rsp_error_o=0 on the next edge, and SHALL take priority over all other events.
REQ-031 Reset during WAIT SHALL abort the request; a store aborted in WAIT SHALL NOT be written.
REQ-032 Reset during RESP SHALL drop the response without requiring a handshake.
REQ-033 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-034 A shared package SHALL hold the FSM state enum (IDLE, WAIT, RESP), the byte-enable width constant 4 and the word width constant 32.
REQ-035 The storage SHALL be one sub-module, data_memory_array: a synchronous byte-enable write / synchronous read RAM of MEMORY_DEPTH words.
REQ-036 The FSM, the counter, the address check and the response registers SHALL reside in data_memory_responder.

Verification
REQ-037 With WAIT_STATES=2: store addr 32'h1001_0004, data 32'hDEAD_BEEF, be 4'hF, then load the same address -> each rsp_valid_o rises 3 cycles after acceptance; the load returns 32'hDEAD_BEEF with error 0.
REQ-038 Partial store: after the REQ-037 store, store be 4'b0010 with data 32'h0000_5500 to 32'h1001_0004, then load it -> the load returns 32'hDEAD_55EF.
REQ-039 Error cases: load 32'h1001_0002 -> error 1, rdata 0; store 32'h1001_0080 (index 32) -> error 1 and memory unchanged; load 32'h1000_FFFC -> error 1.
REQ-040 Backpressure: hold rsp_ready_i=0 for 5 cycles in RESP -> rsp_valid_o, rsp_rdata_o and rsp_error_o stay stable and req_ready_o stays 0; after the handshake, req_ready_o=1 on the next cycle.
REQ-041 Reset in WAIT during a store to 32'h1001_0008 -> next cycle IDLE with rsp_valid_o=0; a later load of 32'h1001_0008 returns the old value.
REQ-042 With WAIT_STATES=0: back-to-back requests with rsp_ready_i held at 1 -> rsp_valid_o rises 1 cycle after each acceptance, and a new acceptance occurs every 3 cycles.

Source files
------------

// File: rtl/data_memory_responder_pkg.sv
// Shared types and constants for the data memory responder and its storage array.
// Word width, byte-enable width and the responder FSM state encoding live here.
package data_memory_responder_pkg;

  localparam int BE_WIDTH   = 4;
  localparam int WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/data_memory_array.sv
// Word-organised RAM with per-byte write enables and a registered read port.
// Contents are deliberately not reset so that data survives a responder reset.
module data_memory_array
  import data_memory_responder_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int ADDR_BITS = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [WORD_WIDTH-1:0] wdata,
  input  logic [BE_WIDTH-1:0]   be,
  output logic [WORD_WIDTH-1:0] rdata
);

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (be[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// Single-outstanding data memory responder: accepts one load/store, waits a fixed
// number of cycles, performs the access, then holds the response until handshaken.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int          MEMORY_DEPTH = 32,
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
  parameter int          WAIT_STATES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [WORD_WIDTH-1:0] req_addr_i,
  input  logic [WORD_WIDTH-1:0] req_wdata_i,
  input  logic [BE_WIDTH-1:0]   req_be_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [WORD_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_error_o
);

  localparam int ADDR_BITS = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

  state_t                state, state_next;
  logic [3:0]            wait_count;
  logic                  lat_write;
  logic [WORD_WIDTH-1:0] lat_addr;
  logic [WORD_WIDTH-1:0] lat_wdata;
  logic [BE_WIDTH-1:0]   lat_be;

  logic                  accept;
  logic                  enter_resp;
  logic                  cur_write;
  logic [WORD_WIDTH-1:0] cur_addr;
  logic [WORD_WIDTH-1:0] cur_wdata;
  logic [BE_WIDTH-1:0]   cur_be;
  logic [WORD_WIDTH-1:0] word_index;
  logic                  addr_error;
  logic                  mem_we;
  logic                  mem_re;
  logic [WORD_WIDTH-1:0] mem_rdata;

  assign req_ready_o = (state == IDLE);
  assign accept      = req_valid_i && req_ready_o;

  // With zero wait states the access happens on the accepting edge itself, so the
  // live request must feed the RAM; otherwise the latched copy is used.
  always_comb begin
    cur_write = lat_write;
    cur_addr  = lat_addr;
    cur_wdata = lat_wdata;
    cur_be    = lat_be;
    if (state == IDLE) begin
      cur_write = req_write_i;
      cur_addr  = req_addr_i;
      cur_wdata = req_wdata_i;
      cur_be    = req_be_i;
    end
  end

  assign word_index = (cur_addr - BASE_ADDR) >> 2;
  assign addr_error = (cur_addr[1:0] != 2'b00) ||
                      (cur_addr < BASE_ADDR) ||
                      (word_index >= 32'(MEMORY_DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_count <= 4'd1) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (rsp_valid_o && rsp_ready_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset wins over the access edge, so an aborted store never reaches the RAM.
  assign mem_we = enter_resp && !reset && cur_write && !addr_error;
  assign mem_re = enter_resp && !reset && !cur_write && !addr_error;

  data_memory_array #(
    .DEPTH    (MEMORY_DEPTH),
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .re   (mem_re),
    .addr (word_index[ADDR_BITS-1:0]),
    .wdata(cur_wdata),
    .be   (cur_be),
    .rdata(mem_rdata)
  );

  // The RAM output lands one edge after entering RESP; the response registers
  // capture it then and stay frozen until the processor takes the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_count  <= 4'd0;
      lat_write   <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_be      <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_error_o <= 1'b0;
    end else begin
      if (accept) begin
        lat_write  <= req_write_i;
        lat_addr   <= req_addr_i;
        lat_wdata  <= req_wdata_i;
        lat_be     <= req_be_i;
        wait_count <= 4'(WAIT_STATES);
      end else if (state == WAIT) begin
        wait_count <= wait_count - 4'd1;
      end

      if (state == RESP) begin
        if (!rsp_valid_o) begin
          rsp_valid_o <= 1'b1;
          rsp_error_o <= addr_error;
          rsp_rdata_o <= (cur_write || addr_error) ? '0 : mem_rdata;
        end else if (rsp_ready_i) begin
          rsp_valid_o <= 1'b0;
          rsp_rdata_o <= '0;
          rsp_error_o <= 1'b0;
        end
      end
    end
  end

endmodule
